// File: rtl/tt_seq_pkg.sv
// rtl/tt_seq_pkg.sv - shared types and sizes for the truth-table sequencer
package tt_seq_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DRIVE  = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } tt_state_t;

   localparam int NUM_ROWS = 16;
   localparam int VEC_W    = 4;
   localparam int RES_W    = 5;
   localparam int SETTLE_W = 8;

endpackage

// File: rtl/tt_result_ram.sv
// rtl/tt_result_ram.sv - 16x5 result store, one write port, registered read, cleared on reset
module tt_result_ram
   import tt_seq_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             i_wr_en,
   input  logic [VEC_W-1:0] i_wr_addr,
   input  logic [RES_W-1:0] i_wr_data,
   input  logic [VEC_W-1:0] i_rd_addr,
   output logic [RES_W-1:0] o_rd_data
);

   logic [RES_W-1:0] r_mem [NUM_ROWS];
   logic [RES_W-1:0] r_rd_data;

   // Read and write share an edge, so a same-address read sees the old entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_ROWS; i++) begin
            r_mem[i] <= '0;
         end
         r_rd_data <= '0;
      end else begin
         r_rd_data <= r_mem[i_rd_addr];
         if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
         end
      end
   end

   assign o_rd_data = r_rd_data;

endmodule

// File: rtl/truth_table_sequencer.sv
// rtl/truth_table_sequencer.sv - sweeps {w,x,y,z} over 16 rows, settles, captures r0..r4
// Optional golden compare (exp_in, mismatch, mismatch_cnt) under TT_GOLDEN_CHECK_EN.
module truth_table_sequencer
   import tt_seq_pkg::*;
#(
   parameter int SETTLE_CYCLES = 60
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic [VEC_W-1:0] vec_out,
   input  logic [RES_W-1:0] res_in,
   output logic             row_valid,
   output logic [VEC_W-1:0] row_idx,
   output logic [RES_W-1:0] row_data,
   input  logic [VEC_W-1:0] rd_addr,
   output logic [RES_W-1:0] rd_data
`ifdef TT_GOLDEN_CHECK_EN
   ,
   input  logic [RES_W-1:0] exp_in,
   output logic             mismatch,
   output logic [RES_W-1:0] mismatch_cnt
`endif
);

   localparam int NUM_IN  = VEC_W;
   localparam int NUM_OUT = RES_W;
   localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
   localparam logic [NUM_IN-1:0]   LAST_ROW    = NUM_IN'(NUM_ROWS - 1);

   tt_state_t           r_state;
   logic [NUM_IN-1:0]   r_row;
   logic [SETTLE_W-1:0] r_settle;
   logic                r_busy;
   logic                r_done;
   logic                r_row_valid;
   logic [NUM_IN-1:0]   r_row_idx;
   logic [NUM_OUT-1:0]  r_row_data;

   logic                w_start_ok;
   logic                w_wr_en;

   assign w_start_ok = start && ((r_state == IDLE) || (r_state == DONE));
   assign w_wr_en    = (r_state == SAMPLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_row       <= '0;
         r_settle    <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_row_valid <= 1'b0;
         r_row_idx   <= '0;
         r_row_data  <= '0;
      end else begin
         r_row_valid <= 1'b0;
         case (r_state)
            IDLE, DONE: begin
               if (start) begin
                  r_state  <= DRIVE;
                  r_row    <= '0;
                  r_settle <= '0;
                  r_done   <= 1'b0;
                  r_busy   <= 1'b1;
               end
            end
            DRIVE: begin
               if (r_settle == SETTLE_LAST) begin
                  r_state <= SAMPLE;
               end else begin
                  r_settle <= r_settle + 1'b1;
               end
            end
            SAMPLE: begin
               r_row_valid <= 1'b1;
               r_row_idx   <= r_row;
               r_row_data  <= res_in;
               // The sweep ends on the last row, so the row counter never wraps.
               if (r_row == LAST_ROW) begin
                  r_state <= DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else begin
                  r_row    <= r_row + 1'b1;
                  r_settle <= '0;
                  r_state  <= DRIVE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   tt_result_ram u_ram (
      .clk       (clk),
      .rst       (rst),
      .i_wr_en   (w_wr_en),
      .i_wr_addr (r_row),
      .i_wr_data (res_in),
      .i_rd_addr (rd_addr),
      .o_rd_data (rd_data)
   );

`ifdef TT_GOLDEN_CHECK_EN
   logic               r_mismatch;
   logic [NUM_OUT-1:0] r_mismatch_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_mismatch     <= 1'b0;
         r_mismatch_cnt <= '0;
      end else begin
         r_mismatch <= 1'b0;
         if (w_start_ok) begin
            r_mismatch_cnt <= '0;
         end else if (r_state == SAMPLE && res_in != exp_in) begin
            r_mismatch <= 1'b1;
            if (r_mismatch_cnt != NUM_OUT'(NUM_ROWS)) begin
               r_mismatch_cnt <= r_mismatch_cnt + 1'b1;
            end
         end
      end
   end

   assign mismatch     = r_mismatch;
   assign mismatch_cnt = r_mismatch_cnt;
`endif

   assign busy      = r_busy;
   assign done      = r_done;
   assign vec_out   = r_row;
   assign row_valid = r_row_valid;
   assign row_idx   = r_row_idx;
   assign row_data  = r_row_data;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// tb/tb_truth_table_sequencer.sv - directed bench, loopback res_in = {^vec_out, vec_out}
module tb_truth_table_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, start, start1, sel;
   logic       busy, done, row_valid;
   logic [3:0] vec_out, row_idx, rd_addr;
   logic [4:0] res_in, row_data, rd_data;
   logic       s1_busy, s1_done, s1_row_valid;
   logic [3:0] s1_vec_out, s1_row_idx;
   logic [4:0] s1_res_in, s1_row_data, s1_rd_data;

   logic       m_busy, m_done, m_row_valid;
   logic [3:0] m_vec_out, m_row_idx;
   logic [4:0] m_row_data;

   int n_checks = 0;
   int n_errors = 0;
   logic [4:0] cap0 [16];

   assign res_in    = {^vec_out, vec_out};
   assign s1_res_in = {^s1_vec_out, s1_vec_out};

   assign m_busy      = sel ? s1_busy      : busy;
   assign m_done      = sel ? s1_done      : done;
   assign m_row_valid = sel ? s1_row_valid : row_valid;
   assign m_vec_out   = sel ? s1_vec_out   : vec_out;
   assign m_row_idx   = sel ? s1_row_idx   : row_idx;
   assign m_row_data  = sel ? s1_row_data  : row_data;

`ifdef TT_GOLDEN_CHECK_EN
   logic       inject;
   logic [4:0] exp_in, s1_exp_in, mismatch_cnt, s1_mismatch_cnt;
   logic       mismatch, s1_mismatch;
   assign exp_in    = (inject && vec_out == 4'd10) ? 5'd0 : res_in;
   assign s1_exp_in = s1_res_in;
`endif

   truth_table_sequencer #(.SETTLE_CYCLES(3)) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
      .vec_out(vec_out), .res_in(res_in), .row_valid(row_valid),
      .row_idx(row_idx), .row_data(row_data), .rd_addr(rd_addr), .rd_data(rd_data)
`ifdef TT_GOLDEN_CHECK_EN
      , .exp_in(exp_in), .mismatch(mismatch), .mismatch_cnt(mismatch_cnt)
`endif
   );

   truth_table_sequencer #(.SETTLE_CYCLES(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .busy(s1_busy), .done(s1_done),
      .vec_out(s1_vec_out), .res_in(s1_res_in), .row_valid(s1_row_valid),
      .row_idx(s1_row_idx), .row_data(s1_row_data), .rd_addr(4'd0), .rd_data(s1_rd_data)
`ifdef TT_GOLDEN_CHECK_EN
      , .exp_in(s1_exp_in), .mismatch(s1_mismatch), .mismatch_cnt(s1_mismatch_cnt)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [4:0] lb(input int i);
      logic [3:0] v;
      v = i[3:0];
      return {^v, v};
   endfunction

   // Count rising edges from the start-sampling edge (edge 1) to the edge that raises done.
   task automatic sweep(input logic use1, input int settle, input bit restart);
      int k, pulses, last_k, mm;
      bit fin;
      sel = use1;
      @(negedge clk);
      if (use1) start1 = 1'b1; else start = 1'b1;
      k = 0; pulses = 0; last_k = 0; mm = 0; fin = 0;
      while (!fin && k < 400) begin
         @(posedge clk);
         k++;
         @(negedge clk);
         if (use1) start1 = 1'b0;
         else start = restart && row_valid && (row_idx == 4'd1 || row_idx == 4'd8);
         if (k == 1) begin
            check("busy_rise", 32'(m_busy), 32'd1);
            check("done_drop", 32'(m_done), 32'd0);
         end
         if (m_row_valid) begin
            check("row_idx", 32'(m_row_idx), 32'(pulses[3:0]));
            check("row_data", 32'(m_row_data), 32'(lb(pulses)));
            if (pulses == 0) check("first_row_lat", 32'(k), 32'(settle + 2));
            else check("row_gap", 32'(k - last_k), 32'(settle + 1));
            if (!use1) cap0[m_row_idx] = m_row_data;
            last_k = k;
            pulses++;
         end
`ifdef TT_GOLDEN_CHECK_EN
         if (!use1 && mismatch) begin
            mm++;
            check("mm_row_idx", 32'(row_idx), 32'd10);
            check("mm_with_valid", 32'(row_valid), 32'd1);
         end
`endif
         if (m_done) fin = 1;
      end
      start = 1'b0;
      start1 = 1'b0;
      check("done_seen", 32'(fin), 32'd1);
      check("done_lat", 32'(k), 32'(16 * (settle + 1) + 1));
      check("pulses", 32'(pulses), 32'd16);
      check("busy_end", 32'(m_busy), 32'd0);
      check("vec_hold", 32'(m_vec_out), 32'd15);
`ifdef TT_GOLDEN_CHECK_EN
      if (!use1) begin
         check("mm_pulses", 32'(mm), inject ? 32'd1 : 32'd0);
         check("mm_cnt", 32'(mismatch_cnt), inject ? 32'd1 : 32'd0);
      end
`endif
   endtask

   task automatic reset_mid();
      int k;
      sel = 1'b0;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      k = 0;
      while (!(row_valid && row_idx == 4'd6) && k < 200) begin
         @(negedge clk);
         k++;
      end
      check("reach_row6", 32'(row_valid && row_idx == 4'd6), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_vec", 32'(vec_out), 32'd0);
      check("rst_valid", 32'(row_valid), 32'd0);
      check("rst_idx", 32'(row_idx), 32'd0);
      check("rst_data", 32'(row_data), 32'd0);
      check("rst_rd", 32'(rd_data), 32'd0);
      rd_addr = 4'd3;
      @(negedge clk);
      check("rd3_cleared", 32'(rd_data), 32'd0);
      check("idle_valid", 32'(row_valid), 32'd0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; start1 = 1'b0; rd_addr = 4'd0; sel = 1'b0;
`ifdef TT_GOLDEN_CHECK_EN
      inject = 1'b0;
`endif
      repeat (3) @(negedge clk);
      check("init_busy", 32'(busy), 32'd0);
      check("init_done", 32'(done), 32'd0);
      check("init_vec", 32'(vec_out), 32'd0);
      check("init_valid", 32'(row_valid), 32'd0);
      check("init_rd", 32'(rd_data), 32'd0);
      check("init1_done", 32'(s1_done), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      sweep(1'b0, 3, 1'b0);
      check("row5_const", 32'(cap0[5]), 32'h05);
      check("row7_const", 32'(cap0[7]), 32'h17);

      for (int i = 0; i < 16; i++) begin
         rd_addr = 4'(i);
         @(negedge clk);
         check("rd_store", 32'(rd_data), 32'(lb(i)));
      end
      check("rd15_const", 32'(rd_data), 32'h0F);

      sweep(1'b0, 3, 1'b1);
      reset_mid();
      sweep(1'b0, 3, 1'b0);
      sweep(1'b1, 1, 1'b0);

`ifdef TT_GOLDEN_CHECK_EN
      inject = 1'b1;
      sweep(1'b0, 3, 1'b0);
      inject = 1'b0;
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
